uart_tx_arbiter: RTL and testbench

//  Shares the UART peripheral transmit path among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART TX path, APB master to the UART
// One byte per grant: poll status until TX FIFO has room, write the byte, pulse req_ready.
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter int         POLL_GAP = 4,
  parameter logic [3:0] USR_ADDR = 4'h0,
  parameter logic [3:0] UWD_ADDR = 4'h8,
  localparam int        IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           PADDR,
  output logic [31:0]          PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int             GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [IDW:0]   NUM_EXT  = (IDW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_ACCESS = 3'd2,
    GAP       = 3'd3,
    WR_SETUP  = 3'd4,
    WR_ACCESS = 3'd5,
    ACK       = 3'd6
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     byte_q;
  logic [GW-1:0]  gap_cnt;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   pick_sum;
  logic [IDW-1:0] pick_cand;
  logic [7:0]     pick_byte;
  logic           tx_not_full;
  logic           unused_prdata;

  assign tx_not_full   = PRDATA[1];
  assign unused_prdata = ^{PRDATA[31:2], PRDATA[0]};

  // Search from rr_ptr upward with wrap; the first asserted valid wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_sum   = '0;
    pick_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pick_sum >= NUM_EXT) begin
        pick_sum = pick_sum - NUM_EXT;
      end
      pick_cand = pick_sum[IDW-1:0];
      if (!pick_found && req_valid[pick_cand]) begin
        pick_found = 1'b1;
        pick_id    = pick_cand;
      end
    end
  end

  always_comb begin
    pick_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_id == IDW'(k)) begin
        pick_byte = req_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      byte_q   <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant_id <= pick_id;
        byte_q   <= pick_byte;
      end
      if (state == RD_ACCESS && PREADY && !tx_not_full) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (state == ACK) begin
        rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = RD_SETUP;
      end
      RD_SETUP: begin
        state_nxt = RD_ACCESS;
      end
      RD_ACCESS: begin
        if (PREADY) begin
          if (tx_not_full)        state_nxt = WR_SETUP;
          else if (POLL_GAP == 0) state_nxt = RD_SETUP;
          else                    state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = RD_SETUP;
      end
      WR_SETUP: begin
        state_nxt = WR_ACCESS;
      end
      WR_ACCESS: begin
        if (PREADY) state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // APB outputs decode purely from state, so address/data hold steady across wait states.
  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = 4'h0;
    PWDATA    = 32'h0;
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      RD_SETUP: begin
        PSEL  = 1'b1;
        PADDR = USR_ADDR;
      end
      RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PADDR   = USR_ADDR;
      end
      WR_SETUP: begin
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PADDR  = UWD_ADDR;
        PWDATA = {24'h0, byte_q};
      end
      WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = UWD_ADDR;
        PWDATA  = {24'h0, byte_q};
      end
      ACK: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (grant_id == IDW'(k)) req_ready[k] = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Includes an APB UART status/data slave model and a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [3:0]    PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA = 32'h0;
  logic          PREADY = 1'b0;
  logic [1:0]    grant_id;
  logic          busy;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .POLL_GAP(4),
    .USR_ADDR(4'h0),
    .UWD_ADDR(4'h8)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_pass = 0;

  // Controls written only by the main sequence.
  int wait_n = 1;
  bit rand_mode = 1'b0;
  int full_budget = 0;

  // Slave/monitor state written only by the negedge process.
  int cyc = 0;
  int acc_cnt = 0;
  int cur_wait = 0;
  int full_given = 0;
  int ack_cnt = 0;
  int stab_err = 0;
  int proto_err = 0;
  int addr_err = 0;
  int order_err = 0;
  int multi_err = 0;
  bit last_notfull = 1'b0;
  bit prev_sel = 1'b0;
  bit prev_en = 1'b0;
  bit prev_done = 1'b0;
  logic [3:0]  p_addr = 4'h0;
  logic        p_write = 1'b0;
  logic [31:0] p_wdata = 32'h0;
  logic [NR-1:0] prev_ready = '0;
  logic        nf;
  logic [31:0] wr_q[$];
  int          read_cyc[$];

  always @(negedge PCLK) begin
    cyc++;
    if (PRESET) begin
      PREADY = 1'b0;
      acc_cnt = 0;
      prev_sel = 1'b0;
      prev_en = 1'b0;
      prev_done = 1'b0;
      last_notfull = 1'b0;
      prev_ready = '0;
    end else begin
      if (req_ready != '0) begin
        ack_cnt++;
        if (prev_ready != '0 || $countones(req_ready) != 1) multi_err++;
      end
      prev_ready = req_ready;
      if (PSEL && prev_sel && !prev_done &&
          (PADDR != p_addr || PWRITE != p_write || PWDATA != p_wdata)) stab_err++;
      if (PENABLE && (!PSEL || !prev_sel || prev_done)) proto_err++;
      if (PSEL && !PENABLE && prev_en && !prev_done) proto_err++;
      if (PSEL && !PENABLE && !PWRITE) read_cyc.push_back(cyc);
      if (PSEL && PENABLE) begin
        if (acc_cnt == 0) cur_wait = rand_mode ? int'($urandom_range(0, 3)) : wait_n;
        if (acc_cnt >= cur_wait) begin
          PREADY = 1'b1;
          if (PWRITE) begin
            if (PADDR != 4'h8) addr_err++;
            if (!last_notfull) order_err++;
            wr_q.push_back(PWDATA);
            last_notfull = 1'b0;
          end else begin
            if (PADDR != 4'h0) addr_err++;
            if (full_given < full_budget) begin
              nf = 1'b0;
              full_given++;
            end else if (rand_mode) begin
              nf = ($urandom_range(0, 2) != 0);
            end else begin
              nf = 1'b1;
            end
            PRDATA = $urandom;
            PRDATA[1] = nf;
            last_notfull = nf;
          end
        end else begin
          PREADY = 1'b0;
        end
        acc_cnt++;
      end else begin
        PREADY = 1'b0;
        acc_cnt = 0;
      end
      prev_done = PSEL && PENABLE && PREADY;
      prev_sel = PSEL;
      prev_en = PENABLE;
      p_addr = PADDR;
      p_write = PWRITE;
      p_wdata = PWDATA;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] last_wr();
    if (wr_q.size() == 0) return 32'hFFFF_FFFF;
    return wr_q[wr_q.size()-1];
  endfunction

  function automatic int id_of(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic wait_ack(input int budget, output logic [NR-1:0] mask, output int lat);
    lat = 0;
    mask = '0;
    while (lat < budget && mask == '0) begin
      tick();
      lat++;
      mask = req_ready;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    PRESET = 1'b1;
    repeat (2) tick();
    PRESET = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [31:0]   data;
    int            exp_id;
    logic [7:0]    exp_byte;
  } vec_t;

  vec_t tbl[8];

  int len[NR];
  int pos[NR];
  int cnt[NR];
  logic [7:0] mem[NR][8];
  int exp_id_q[$];
  logic [7:0] exp_b_q[$];

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (pos[i] < len[i]);
      req_data[8*i +: 8] = (pos[i] < len[i]) ? mem[i][pos[i]] : 8'h00;
    end
  endtask

  task automatic build_model();
    int p;
    int left;
    int i;
    p = 0;
    left = 0;
    for (int k = 0; k < NR; k++) begin
      cnt[k] = len[k];
      left += len[k];
    end
    while (left > 0) begin
      for (int k = 0; k < NR; k++) begin
        i = (p + k) % NR;
        if (cnt[i] > 0) begin
          exp_id_q.push_back(i);
          exp_b_q.push_back(mem[i][len[i] - cnt[i]]);
          cnt[i]--;
          left--;
          p = (i + 1) % NR;
          break;
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] mask;
    int lat, w0, r0, a0, t, id;

    tbl[0] = '{4'b0001, 32'h0000_0041, 0, 8'h41};
    tbl[1] = '{4'b0001, 32'h0000_0042, 0, 8'h42};
    tbl[2] = '{4'b1001, 32'hA3A2_A1A0, 3, 8'hA3};
    tbl[3] = '{4'b1001, 32'hB3B2_B1B0, 0, 8'hB0};
    tbl[4] = '{4'b0110, 32'hC3C2_C1C0, 1, 8'hC1};
    tbl[5] = '{4'b0110, 32'hD3D2_D1D0, 2, 8'hD2};
    tbl[6] = '{4'b0011, 32'hE3E2_E1E0, 0, 8'hE0};
    tbl[7] = '{4'b1111, 32'hF3F2_F1F0, 1, 8'hF1};

    req_valid = '0;
    req_data = '0;
    PRESET = 1'b1;
    tick();
    tick();
    chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR}, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_misc", {req_ready, grant_id, busy}, 0);
    PRESET = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    wait_n = 1;
    for (int r = 0; r < 8; r++) begin
      w0 = wr_q.size();
      r0 = read_cyc.size();
      req_data = tbl[r].data;
      req_valid = tbl[r].valid;
      wait_ack(40, mask, lat);
      req_valid = '0;
      chk($sformatf("vec%0d_ready", r), mask, 64'(1) << tbl[r].exp_id);
      chk($sformatf("vec%0d_grant", r), grant_id, tbl[r].exp_id);
      chk($sformatf("vec%0d_latency", r), lat, 7);
      chk($sformatf("vec%0d_writes", r), wr_q.size() - w0, 1);
      chk($sformatf("vec%0d_pwdata", r), last_wr(), {24'h0, tbl[r].exp_byte});
      chk($sformatf("vec%0d_reads", r), read_cyc.size() - r0, 1);
      tick();
    end

    // All four requesters held valid: strict rotation, wrapping back to 0.
    do_reset();
    wait_n = 0;
    req_data = 32'hA3A2_A1A0;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, mask, lat);
      chk($sformatf("rot%0d_id", k), id_of(mask), k % NR);
      chk($sformatf("rot%0d_pwdata", k), last_wr(), 32'hA0 + (k % NR));
    end
    req_valid = '0;
    tick();

    // TX full for three polls.
    w0 = wr_q.size();
    r0 = read_cyc.size();
    full_budget = full_given + 3;
    req_data = 32'h0000_005A;
    req_valid = 4'b0001;
    wait_ack(200, mask, lat);
    req_valid = '0;
    chk("poll_ready", mask, 4'b0001);
    chk("poll_reads", read_cyc.size() - r0, 4);
    chk("poll_writes", wr_q.size() - w0, 1);
    chk("poll_pwdata", last_wr(), 32'h5A);
    for (int k = 0; k < 3; k++) begin
      if (read_cyc.size() >= r0 + k + 2)
        chk($sformatf("poll_gap%0d", k), read_cyc[r0+k+1] - read_cyc[r0+k] - 2, 4);
      else
        chk($sformatf("poll_gap%0d", k), 0, 4);
    end
    tick();

    // Five wait states on both transfers.
    wait_n = 5;
    w0 = wr_q.size();
    a0 = ack_cnt;
    req_data = 32'h0055_0000;
    req_valid = 4'b0100;
    wait_ack(100, mask, lat);
    req_valid = '0;
    chk("slow_ready", mask, 4'b0100);
    chk("slow_latency", lat, 15);
    repeat (10) tick();
    chk("slow_writes", wr_q.size() - w0, 1);
    chk("slow_acks", ack_cnt - a0, 1);
    chk("slow_pwdata", last_wr(), 32'h55);

    // Reset in the middle of the data write.
    wait_n = 60;
    w0 = wr_q.size();
    a0 = ack_cnt;
    req_data = 32'h0000_7700;
    req_valid = 4'b0010;
    t = 0;
    while (!(PSEL && PENABLE && PWRITE) && t < 200) begin
      tick();
      t++;
    end
    chk("abort_reached_wr", {PSEL, PENABLE, PWRITE}, 3'b111);
    PRESET = 1'b1;
    #1;
    chk("abort_apb", {PSEL, PENABLE, PWRITE, PADDR}, 0);
    chk("abort_misc", {PWDATA, req_ready, grant_id, busy}, 0);
    tick();
    chk("abort_apb_edge", {PSEL, PENABLE, PWRITE, PADDR}, 0);
    wait_n = 0;
    req_valid = '0;
    tick();
    PRESET = 1'b0;
    tick();
    chk("abort_no_ack", ack_cnt - a0, 0);
    chk("abort_no_write", wr_q.size() - w0, 0);
    req_data = 32'h4433_2211;
    req_valid = 4'hF;
    wait_ack(40, mask, lat);
    req_valid = '0;
    chk("abort_restart_id", id_of(mask), 0);
    chk("abort_restart_pwdata", last_wr(), 32'h11);
    tick();

    // req1 stays valid; req3 must be served before req1 again.
    req_data = 32'h0000_6100;
    req_valid = 4'b0010;
    wait_ack(40, mask, lat);
    chk("starve_first", id_of(mask), 1);
    req_data = 32'h6300_6200;
    req_valid = 4'b1010;
    wait_ack(40, mask, lat);
    chk("starve_req3", id_of(mask), 3);
    chk("starve_req3_data", last_wr(), 32'h63);
    req_valid = 4'b0010;
    wait_ack(40, mask, lat);
    req_valid = '0;
    chk("starve_req1", id_of(mask), 1);
    chk("starve_req1_data", last_wr(), 32'h62);
    tick();

    // Randomized traffic, random wait states and random full status.
    for (int round = 0; round < 4; round++) begin
      do_reset();
      exp_id_q.delete();
      exp_b_q.delete();
      for (int i = 0; i < NR; i++) begin
        len[i] = $urandom_range(0, 6);
        pos[i] = 0;
        for (int j = 0; j < 8; j++) mem[i][j] = 8'($urandom);
      end
      build_model();
      rand_mode = 1'b1;
      drive_reqs();
      t = 0;
      while (exp_id_q.size() > 0 && t < 6000) begin
        tick();
        t++;
        if (req_ready != '0) begin
          id = id_of(req_ready);
          chk($sformatf("rand%0d_id", round), id, exp_id_q[0]);
          chk($sformatf("rand%0d_pwdata", round), last_wr(), {24'h0, exp_b_q[0]});
          void'(exp_id_q.pop_front());
          void'(exp_b_q.pop_front());
          if (id >= 0) pos[id]++;
          drive_reqs();
        end
      end
      chk($sformatf("rand%0d_drained", round), exp_id_q.size(), 0);
      rand_mode = 1'b0;
      req_valid = '0;
      repeat (3) tick();
    end

    chk("apb_stable", stab_err, 0);
    chk("apb_protocol", proto_err, 0);
    chk("apb_address", addr_err, 0);
    chk("write_after_notfull", order_err, 0);
    chk("ready_single_pulse", multi_err, 0);
    chk("writes_eq_acks", wr_q.size(), ack_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
